trigger_ctrl: RTL
=================

Name: trigger_ctrl

Overview:
- Drives the `TRIGGER` input of the pipelined register file, which forces `t0` (x5) to 1 on a pulse.
- Observes that file's `a0` output to measure the program's response.
- Synchronises and debounces a raw push-button, then emits exactly one single-cycle trigger pulse per press.
- Times the cycles until `a0` leaves its pre-trigger value and reaches a programmable completion value, then presents the result.

Parameters:
- WD, 32, width of the observed `a0` word.
- DEB_CYCLES, 4, consecutive synchronised-high cycles required to accept a press (≥1).
- CW, 16, width of the latency/timeout counter.
- DONE_VAL, 32'hFF, `a0` value that marks program completion.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- btn_raw  input  1  asynchronous push-button level.
- a0  input  WD  live `a0` output of the register file.
- trigger  output  1  one-cycle pulse to the register-file `TRIGGER` pin.
- busy  output  1  high from accepted press until return to IDLE.
- done  output  1  one-cycle pulse when `a0` == DONE_VAL.
- timeout  output  1  one-cycle pulse when the counter saturates before completion.
- latency  output  CW  cycles from trigger to completion, held until the next trigger.
- a0_start  output  WD  `a0` sampled in the FIRE cycle.

Behaviour:
- Reset (`rst` high at a clock edge):
  - State → IDLE.
  - `trigger`, `busy`, `done`, `timeout` = 0.
  - `latency` = 0, `a0_start` = 0.
  - Synchroniser flops = 0, debounce counter = 0.
  - Reset mid-operation aborts from any state with no trigger/done pulse in that cycle.
- Synchroniser: `btn_raw` passes two flops to give `btn_s`. All FSM decisions use `btn_s` only.
- IDLE:
  - `btn_s` = 1 → DEBOUNCE, deb counter = 1.
- DEBOUNCE:
  - `btn_s` = 1: counter increments.
  - When counter == DEB_CYCLES → FIRE.
  - `btn_s` = 0 at any point → IDLE, counter cleared.
  - With DEB_CYCLES = 1, the cycle after entering DEBOUNCE goes to FIRE.
- FIRE (exactly 1 cycle):
  - `trigger` = 1, `busy` = 1.
  - `a0_start` ← `a0`; latency counter ← 0.
  - → WAIT.
- WAIT:
  - `busy` = 1; counter increments each cycle.
  - If `a0` == DONE_VAL at a clock edge: `latency` ← counter+1, `done` pulses next cycle, → RELEASE.
  - Else if counter+1 == 2^CW−1 (saturation): `latency` ← 2^CW−1, `timeout` pulses, → RELEASE.
  - Completion has priority if both hold in the same cycle.
  - If `a0_start` already equals DONE_VAL, completion needs `a0` first to differ from DONE_VAL, then return to it. The latency still counts from FIRE.
- RELEASE:
  - `busy` = 1.
  - Waits for `btn_s` = 0 → IDLE.
  - A held button never produces a second trigger.
- `busy` = 0 only in IDLE and DEBOUNCE.
- `trigger` is never high two consecutive cycles. At most one trigger per FIRE visit.
- `latency` and `a0_start` hold their values outside FIRE/WAIT updates.
- Arithmetic is unsigned. Counter width is CW and it saturates, never wraps.

Test Plan:
- Reset then idle: assert `rst` 2 cycles with `btn_raw` = 1 → all outputs 0. Release `rst`, keep `btn_raw` = 1 → `trigger` pulses exactly once, at cycle 2 (sync) + 4 (debounce) + 1 after reset release, for DEB_CYCLES = 4.
- Bounce rejection: `btn_raw` toggles 1,1,0,1,1,1,0 per cycle → no trigger, `busy` stays 0. A subsequent stable press yields one trigger.
- Normal completion: after trigger, `a0` = 0 for 9 cycles, then 0xFF → `done` one pulse, `latency` = 10, `a0_start` = 0. Hold the button → no second trigger. Release, press again → new trigger.
- Timeout: CW = 4, `a0` never 0xFF → `timeout` pulses once with `latency` = 15, `done` never asserts.
- Pre-completed start: `a0` = 0xFF at FIRE, stays 0xFF for 5 cycles, then 0x01, then 0xFF → `done` only on the final transition.
- Reset mid-WAIT: assert `rst` 3 cycles after trigger → `busy`/`latency`/`a0_start` = 0 next cycle, no `done`. Then `a0` = 0xFF produces no pulse.

Source files
------------

// File: rtl/trigger_ctrl.sv
// Push-button trigger controller: synchronises and debounces a press, fires one
// TRIGGER pulse into the register file, then times how long a0 takes to reach DONE_VAL.
module trigger_ctrl #(
  parameter int             WD         = 32,
  parameter int             DEB_CYCLES = 4,
  parameter int             CW         = 16,
  parameter logic [WD-1:0]  DONE_VAL   = 'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_raw,
  input  logic [WD-1:0] a0,
  output logic          trigger,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] latency,
  output logic [WD-1:0] a0_start
);

  localparam int             DCW     = $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_MAX = DCW'(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_FIRE,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_sync2;
  logic [DCW-1:0]  r_deb;
  logic [CW-1:0]   r_cnt;
  logic            r_armed;
  logic            r_done;
  logic            r_timeout;
  logic [CW-1:0]   r_latency;
  logic [WD-1:0]   r_a0_start;

  logic            w_btn_s;
  logic            w_hit;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_complete;
  logic            w_sat;

  assign w_btn_s   = r_sync2;
  assign w_hit     = (a0 == DONE_VAL);
  assign w_cnt_inc = r_cnt + 1'b1;

  // r_armed is cleared at FIRE when a0 already sits at DONE_VAL, so completion
  // then needs a0 to leave DONE_VAL and come back.
  assign w_complete = (r_state == S_WAIT) && w_hit && r_armed;
  assign w_sat      = (r_state == S_WAIT) && !w_complete && (w_cnt_inc == CNT_MAX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_btn_s) w_next = S_DEBOUNCE;
      S_DEBOUNCE: begin
        if (!w_btn_s)              w_next = S_IDLE;
        else if (r_deb == DEB_MAX) w_next = S_FIRE;
      end
      S_FIRE:     w_next = S_WAIT;
      S_WAIT:     if (w_complete || w_sat) w_next = S_RELEASE;
      S_RELEASE:  if (!w_btn_s) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_deb      <= '0;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_latency  <= '0;
      r_a0_start <= '0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_state   <= w_next;
      r_done    <= w_complete;
      r_timeout <= w_sat;
      case (r_state)
        S_IDLE:     r_deb <= w_btn_s ? DCW'(1) : '0;
        S_DEBOUNCE: begin
          if (!w_btn_s)              r_deb <= '0;
          else if (r_deb != DEB_MAX) r_deb <= r_deb + 1'b1;
        end
        S_FIRE: begin
          r_a0_start <= a0;
          r_cnt      <= '0;
          r_armed    <= !w_hit;
        end
        S_WAIT: begin
          if (!w_hit) r_armed <= 1'b1;
          // counter saturates at CNT_MAX instead of wrapping
          if (w_complete)  r_latency <= w_cnt_inc;
          else if (w_sat)  r_latency <= CNT_MAX;
          else             r_cnt     <= w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign trigger  = (r_state == S_FIRE);
  assign busy     = (r_state == S_FIRE) || (r_state == S_WAIT) || (r_state == S_RELEASE);
  assign done     = r_done;
  assign timeout  = r_timeout;
  assign latency  = r_latency;
  assign a0_start = r_a0_start;

endmodule
